// File: rtl/alu_exec_unit.sv
// Handshaked scalar / packed-SIMD ALU execute stage with registered result
// and an iterative shift-add multiplier (low product bits only).
module alu_exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_src,
  input  logic              ss_src,
  input  logic [3:0]        alu_control,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   write_data,
  input  logic [XLEN-1:0]   imm_ext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   write_data_out,
  output logic              zero,
  output logic [LANES-1:0]  lane_zero
);

  localparam int unsigned LANE_W = XLEN / LANES;
  localparam int unsigned XSH    = $clog2(XLEN);
  localparam int unsigned LSH    = $clog2(LANE_W);
  localparam int unsigned CNT_W  = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    r_wdata;
  logic               r_zero;
  logic [LANES-1:0]   r_lane_zero;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    r_acc;
  logic               r_simd;
  logic [CNT_W-1:0]   r_cnt;

  logic [XLEN-1:0]    w_b;
  logic [XLEN-1:0]    w_alu;
  logic               w_accept;
  logic               w_is_mul;
  logic [XLEN-1:0]    w_acc_nx;
  logic [XLEN-1:0]    w_mcand_nx;
  logic [XLEN-1:0]    w_mplier_nx;

  // Scalar mode reports the whole-word zero flag on every lane bit.
  function automatic logic [LANES-1:0] f_lane_zero(input logic [XLEN-1:0] v,
                                                   input logic simd);
    logic [LANES-1:0] lz;
    for (int unsigned l = 0; l < LANES; l++)
      lz[l] = (v[l*LANE_W +: LANE_W] == '0);
    if (!simd)
      lz = {LANES{v == '0}};
    return lz;
  endfunction

  assign w_b      = alu_src ? imm_ext : write_data;
  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (MUL_EN != 0) && (alu_control == OP_MUL);

  always_comb begin : p_alu
    logic [LANE_W-1:0] la, lb, lr;
    logic [LSH-1:0]    lsh;
    logic [XSH-1:0]    ssh;
    w_alu = '0;
    la    = '0;
    lb    = '0;
    lr    = '0;
    lsh   = '0;
    ssh   = w_b[XSH-1:0];
    if (!ss_src) begin
      case (alu_control)
        OP_ADD:  w_alu = src_a + w_b;
        OP_SUB:  w_alu = src_a - w_b;
        OP_AND:  w_alu = src_a & w_b;
        OP_OR:   w_alu = src_a | w_b;
        OP_XOR:  w_alu = src_a ^ w_b;
        OP_SLT:  w_alu = XLEN'($signed(src_a) < $signed(w_b));
        OP_SLTU: w_alu = XLEN'(src_a < w_b);
        OP_SLL:  w_alu = src_a << ssh;
        OP_SRL:  w_alu = src_a >> ssh;
        OP_SRA:  w_alu = $signed(src_a) >>> ssh;
        default: w_alu = '0;
      endcase
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        la  = src_a[l*LANE_W +: LANE_W];
        lb  = w_b[l*LANE_W +: LANE_W];
        lsh = lb[LSH-1:0];
        case (alu_control)
          OP_ADD:  lr = la + lb;
          OP_SUB:  lr = la - lb;
          OP_AND:  lr = la & lb;
          OP_OR:   lr = la | lb;
          OP_XOR:  lr = la ^ lb;
          OP_SLT:  lr = LANE_W'($signed(la) < $signed(lb));
          OP_SLTU: lr = LANE_W'(la < lb);
          OP_SLL:  lr = la << lsh;
          OP_SRL:  lr = la >> lsh;
          OP_SRA:  lr = $signed(la) >>> lsh;
          default: lr = '0;
        endcase
        w_alu[l*LANE_W +: LANE_W] = lr;
      end
    end
  end

  // One shift-add step; in SIMD mode each lane keeps its own carries and shifts.
  always_comb begin : p_mul_step
    w_acc_nx    = r_acc;
    w_mcand_nx  = r_mcand << 1;
    w_mplier_nx = r_mplier >> 1;
    if (!r_simd) begin
      if (r_mplier[0])
        w_acc_nx = r_acc + r_mcand;
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        w_acc_nx[l*LANE_W +: LANE_W] = r_acc[l*LANE_W +: LANE_W] +
          (r_mplier[l*LANE_W] ? r_mcand[l*LANE_W +: LANE_W] : '0);
        w_mcand_nx[l*LANE_W +: LANE_W]  = r_mcand[l*LANE_W +: LANE_W] << 1;
        w_mplier_nx[l*LANE_W +: LANE_W] = r_mplier[l*LANE_W +: LANE_W] >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_wdata     <= '0;
      r_zero      <= 1'b1;
      r_lane_zero <= '1;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_simd      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wdata <= write_data;
            if (w_is_mul) begin
              r_mcand  <= src_a;
              r_mplier <= w_b;
              r_acc    <= '0;
              r_simd   <= ss_src;
              r_cnt    <= ss_src ? CNT_W'(LANE_W) : CNT_W'(XLEN);
              r_state  <= S_MUL;
            end else begin
              r_result    <= w_alu;
              r_zero      <= (w_alu == '0);
              r_lane_zero <= f_lane_zero(w_alu, ss_src);
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= w_mcand_nx;
          r_mplier <= w_mplier_nx;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_result    <= r_acc;
          r_zero      <= (r_acc == '0);
          r_lane_zero <= f_lane_zero(r_acc, r_simd);
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign alu_result     = r_result;
  assign write_data_out = r_wdata;
  assign zero           = r_zero;
  assign lane_zero      = r_lane_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + randomised bench for alu_exec_unit: scoreboard of expected
// results checked whenever the unit hands a result downstream.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        alu_src;
  logic        ss_src;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] imm_ext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic [31:0] write_data_out;
  logic        zero;
  logic [3:0]  lane_zero;

  alu_exec_unit #(.XLEN(32), .LANES(4), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .ss_src(ss_src), .alu_control(alu_control),
    .src_a(src_a), .write_data(write_data), .imm_ext(imm_ext),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .write_data_out(write_data_out), .zero(zero), .lane_zero(lane_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic        z;
    logic [3:0]  lz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_lz(input logic [31:0] r, input logic simd);
    if (!simd) return {4{r == 32'd0}};
    return {r[31:24] == 8'd0, r[23:16] == 8'd0, r[15:8] == 8'd0, r[7:0] == 8'd0};
  endfunction

  // Reference model with fixed 8-bit lanes; MUL uses the native operator.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic simd,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  x, y, z;
    r = 32'd0;
    if (!simd) begin
      case (op)
        4'd0:  r = a + b;
        4'd1:  r = a - b;
        4'd2:  r = a & b;
        4'd3:  r = a | b;
        4'd4:  r = a ^ b;
        4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd6:  r = (a < b) ? 32'd1 : 32'd0;
        4'd7:  r = a << b[4:0];
        4'd8:  r = a >> b[4:0];
        4'd9:  r = $signed(a) >>> b[4:0];
        4'd10: r = a * b;
        default: r = 32'd0;
      endcase
    end else begin
      for (int i = 0; i < 4; i++) begin
        x = a[8*i +: 8];
        y = b[8*i +: 8];
        case (op)
          4'd0:  z = x + y;
          4'd1:  z = x - y;
          4'd2:  z = x & y;
          4'd3:  z = x | y;
          4'd4:  z = x ^ y;
          4'd5:  z = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
          4'd6:  z = (x < y) ? 8'd1 : 8'd0;
          4'd7:  z = x << y[2:0];
          4'd8:  z = x >> y[2:0];
          4'd9:  z = $signed(x) >>> y[2:0];
          4'd10: z = x * y;
          default: z = 8'd0;
        endcase
        r[8*i +: 8] = z;
      end
    end
    return r;
  endfunction

  // Caller is just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic simd, input logic src,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] imm,
                       input logic [31:0] res, input logic push, output int waits);
    alu_control = op; ss_src = simd; alu_src = src;
    src_a = a; write_data = wd; imm_ext = imm; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready)
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    else if (push)
      sb.push_back('{res, wd, res == 32'd0, exp_lz(res, simd)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("out_with_nothing_pending", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", alu_result, e.res);
        chk("sb_wdata", write_data_out, e.wd);
        chk("sb_zero", {31'b0, zero}, {31'b0, e.z});
        chk("sb_lane_zero", {28'b0, lane_zero}, {28'b0, e.lz});
      end
    end
  end

  initial begin
    int w, lat, busy, seen, total, n;
    logic [3:0]  op;
    logic        simd, src;
    logic [31:0] a, wd, imm;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_src = 1'b0; ss_src = 1'b0;
    alu_control = 4'd0; src_a = '0; write_data = '0; imm_ext = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_wdata", write_data_out, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_lane_zero", {28'b0, lane_zero}, 32'hF);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Scalar ADD with immediate: 5 + (-5) = 0
    issue(4'd0, 1'b0, 1'b1, 32'h0000_0005, 32'h1234_5678, 32'hFFFF_FFFB, 32'h0, 1'b1, w);
    @(negedge clk);
    chk("add_imm_valid", {31'b0, out_valid}, 32'd1);
    chk("add_imm_result", alu_result, 32'h0);
    chk("add_imm_zero", {31'b0, zero}, 32'd1);
    chk("add_imm_lane_zero", {28'b0, lane_zero}, 32'hF);
    @(posedge clk); #1;

    // SIMD ADD, per-lane wrap
    issue(4'd0, 1'b1, 1'b0, 32'hFF01_7F80, 32'h0101_0180, 32'h0, 32'h0002_8000, 1'b1, w);
    @(negedge clk);
    chk("simd_add_lane_zero", {28'b0, lane_zero}, 32'h9);
    chk("simd_add_zero", {31'b0, zero}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back: reserved opcode, SIMD SRA, scalar SRA
    issue(4'hC, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, w);
    issue(4'd9, 1'b1, 1'b0, 32'h80F0_4010, 32'h0104_0201, 32'h0, 32'hC0FF_1008, 1'b1, w);
    issue(4'd9, 1'b0, 1'b0, 32'h80F0_4010, 32'h0000_0004, 32'h0, 32'hF80F_0401, 1'b1, w);

    // Scalar MUL: 33-cycle latency, unit busy throughout
    issue(4'd10, 1'b0, 1'b0, 32'h0001_0003, 32'h0000_0007, 32'h0, 32'h0007_0015, 1'b1, w);
    lat = 0; busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    chk("mul_scalar_latency", lat, 33);
    chk("mul_scalar_in_ready_high", busy, 0);
    @(posedge clk); #1;

    // SIMD MUL: 9-cycle latency
    issue(4'd10, 1'b1, 1'b0, 32'h0302_FF10, 32'h0203_0210, 32'h0, 32'h0606_FE00, 1'b1, w);
    lat = 0; busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    chk("mul_simd_latency", lat, 9);
    chk("mul_simd_in_ready_high", busy, 0);
    @(posedge clk); #1;

    // Backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    issue(4'd4, 1'b0, 1'b0, 32'hA5A5_0000, 32'h0F0F_0F0F, 32'h0, 32'hAAAA_0F0F, 1'b1, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_result", alu_result, 32'hAAAA_0F0F);
      chk("bp_wdata", write_data_out, 32'h0F0F_0F0F);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd3, 1'b0, 1'b1, 32'h1200_0034, 32'h0000_0001, 32'h0000_5600, 32'h1200_5634, 1'b1, w);
    chk("bp_same_cycle_accept", w, 0);
    @(negedge clk);
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_result", alu_result, 32'h1200_5634);
    @(posedge clk); #1;

    // Reset four cycles into a MUL: aborted, nothing emitted
    issue(4'd10, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0, 1'b0, w);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", alu_result, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    @(posedge clk); #1;

    // Random non-MUL ops at full throughput
    total = 0;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10) op = 4'd1;
      simd = 1'($urandom_range(0, 1));
      src  = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; imm = $urandom;
      issue(op, simd, src, a, wd, imm, ref_alu(op, simd, a, src ? imm : wd), 1'b1, w);
      total += w;
    end
    chk("rand_throughput_waits", total, 0);

    // A few random MULs checked against the native product
    for (int k = 0; k < 4; k++) begin
      simd = 1'(k % 2);
      a = $urandom; wd = $urandom;
      issue(4'd10, simd, 1'b0, a, wd, 32'h0, ref_alu(4'd10, simd, a, wd), 1'b1, w);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
